// File: rtl/mult_resp_serializer.sv
// Buffers multiplier product words in a small FIFO and ships each one out
// bit-serially, MSB first, over a valid/ready bit stream.
module mult_resp_serializer #(
    parameter int BIT_WIDTH = 4,
    parameter int OUT_WIDTH = 2 * BIT_WIDTH,
    parameter int DEPTH     = 4,
    parameter int CNT_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [OUT_WIDTH-1:0]         in_data,
    output logic                         tx_valid,
    input  logic                         tx_ready,
    output logic                         tx_bit,
    output logic                         tx_last,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level,
    output logic [CNT_WIDTH-1:0]         word_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (OUT_WIDTH > 1) ? $clog2(OUT_WIDTH) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(OUT_WIDTH - 1);
    localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(DEPTH);

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    logic [OUT_WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]     r_wr_ptr;
    logic [PTR_W-1:0]     r_rd_ptr;
    logic [LVL_W-1:0]     r_level;
    state_t               r_state;
    logic [OUT_WIDTH-1:0] r_shreg;
    logic [IDX_W-1:0]     r_bit_idx;
    logic                 r_tx_valid;
    logic                 r_tx_last;
    logic [CNT_WIDTH-1:0] r_word_cnt;

    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    state_t               w_state_nxt;
    logic [OUT_WIDTH-1:0] w_shreg_nxt;
    logic [IDX_W-1:0]     w_idx_nxt;
    logic                 w_valid_nxt;
    logic                 w_last_nxt;
    logic                 w_cnt_inc;

    assign w_full     = (r_level == LVL_FULL);
    assign in_ready   = !w_full;
    assign w_push     = in_valid && !w_full;
    assign tx_valid   = r_tx_valid;
    assign tx_bit     = r_shreg[OUT_WIDTH-1];
    assign tx_last    = r_tx_last;
    assign fifo_level = r_level;
    assign word_cnt   = r_word_cnt;

    // Serializer next-state: loads from the FIFO head, shifts on accept, chains words without a bubble
    always_comb begin
        w_pop       = 1'b0;
        w_state_nxt = r_state;
        w_shreg_nxt = r_shreg;
        w_idx_nxt   = r_bit_idx;
        w_valid_nxt = r_tx_valid;
        w_last_nxt  = r_tx_last;
        w_cnt_inc   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_level != '0) begin
                    w_pop       = 1'b1;
                    w_shreg_nxt = r_mem[r_rd_ptr];
                    w_idx_nxt   = IDX_TOP;
                    w_valid_nxt = 1'b1;
                    w_last_nxt  = 1'b0;
                    w_state_nxt = SHIFT;
                end else begin
                    w_valid_nxt = 1'b0;
                    w_last_nxt  = 1'b0;
                end
            end
            SHIFT: begin
                if (tx_ready) begin
                    if (r_tx_last) begin
                        w_cnt_inc = 1'b1;
                        if (r_level != '0) begin
                            w_pop       = 1'b1;
                            w_shreg_nxt = r_mem[r_rd_ptr];
                            w_idx_nxt   = IDX_TOP;
                            w_valid_nxt = 1'b1;
                            w_last_nxt  = 1'b0;
                        end else begin
                            w_shreg_nxt = {r_shreg[OUT_WIDTH-2:0], 1'b0};
                            w_idx_nxt   = '0;
                            w_valid_nxt = 1'b0;
                            w_last_nxt  = 1'b0;
                            w_state_nxt = IDLE;
                        end
                    end else begin
                        w_shreg_nxt = {r_shreg[OUT_WIDTH-2:0], 1'b0};
                        w_idx_nxt   = r_bit_idx - IDX_W'(1);
                        w_last_nxt  = (r_bit_idx == IDX_W'(1));
                    end
                end else begin
                    w_shreg_nxt = r_shreg;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_valid_nxt = 1'b0;
                w_last_nxt  = 1'b0;
            end
        endcase
    end

    // FIFO storage, pointers and occupancy
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= in_data;
                r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LVL_W'(1);
                2'b01:   r_level <= r_level - LVL_W'(1);
                default: r_level <= r_level;
            endcase
        end
    end

    // Serializer state, shift register and transmitted-word counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_shreg    <= '0;
            r_bit_idx  <= '0;
            r_tx_valid <= 1'b0;
            r_tx_last  <= 1'b0;
            r_word_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_shreg    <= w_shreg_nxt;
            r_bit_idx  <= w_idx_nxt;
            r_tx_valid <= w_valid_nxt;
            r_tx_last  <= w_last_nxt;
            if (w_cnt_inc) begin
                r_word_cnt <= r_word_cnt + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_mult_resp_serializer.sv
// Scoreboard bench: expected words queued at push time, rebuilt from the
// serial stream and compared in order.
module tb_mult_resp_serializer;

    localparam int OW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [OW-1:0] in_data = '0;
    logic          tx_ready = 1'b0;
    logic          in_ready;
    logic          tx_valid;
    logic          tx_bit;
    logic          tx_last;
    logic [2:0]    fifo_level;
    logic [31:0]   word_cnt;

    mult_resp_serializer #(.BIT_WIDTH(4), .OUT_WIDTH(OW), .DEPTH(4), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .tx_bit(tx_bit), .tx_last(tx_last), .fifo_level(fifo_level),
        .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [7:0] p;
    } vec_t;

    vec_t          vt [8];
    logic [OW-1:0] q [$];
    int            n_tests = 0;
    int            n_fail = 0;
    int            tot = 0;
    int            ready_mode = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] smul(input logic [3:0] a, input logic [3:0] b);
        logic signed [7:0] sa;
        logic signed [7:0] sb;
        sa = {{4{a[3]}}, a};
        sb = {{4{b[3]}}, b};
        return sa * sb;
    endfunction

    // tx_ready pattern: 0 always, 1 toggle, 2 stalled, else random
    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            2:       tx_ready = 1'b0;
            default: tx_ready = ($urandom_range(0, 3) != 0);
        endcase
    end

    logic [OW-1:0] acc = '0;
    int            nb = 0;
    logic          stall_prev = 1'b0;
    logic [2:0]    held = '0;

    // Deserializer / scoreboard compare, plus hold-under-backpressure check
    always @(negedge clk) begin
        if (rst) begin
            nb = 0;
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) check("hold", {tx_valid, tx_bit, tx_last}, held);
            stall_prev = tx_valid && !tx_ready;
            held = {tx_valid, tx_bit, tx_last};
            if (tx_valid && tx_ready) begin
                check("tx_last", tx_last, (nb == OW - 1));
                acc = {acc[OW-2:0], tx_bit};
                nb++;
                if (nb == OW) begin
                    nb = 0;
                    if (q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL word: got %02h, none expected", acc);
                    end else begin
                        check("word", acc, q.pop_front());
                    end
                end
            end
        end
    end

    task automatic push_word(input logic [OW-1:0] d, input logic [OW-1:0] e);
        int guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (!in_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: in_ready got 0 expected 1");
        end else begin
            in_valid = 1'b1;
            in_data  = d;
            q.push_back(e);
            tot++;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic push_expect(input logic [OW-1:0] d, input logic acc_ok);
        check("in_ready", in_ready, acc_ok);
        in_valid = 1'b1;
        in_data  = d;
        if (acc_ok) begin
            q.push_back(d);
            tot++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int guard = 0;
        while (!(q.size() == 0 && !tx_valid) && guard < 500) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check({name, "_drain"}, (q.size() == 0 && !tx_valid), 1'b1);
        check({name, "_word_cnt"}, word_cnt, tot);
        check({name, "_level"}, fifo_level, 3'd0);
    endtask

    initial begin
        vt[0] = '{4'h8, 4'h8, 8'h40};
        vt[1] = '{4'h7, 4'h7, 8'h31};
        vt[2] = '{4'h8, 4'h7, 8'hC8};
        vt[3] = '{4'hF, 4'h1, 8'hFF};
        vt[4] = '{4'h0, 4'h5, 8'h00};
        vt[5] = '{4'h3, 4'hC, 8'hF4};
        vt[6] = '{4'hD, 4'hB, 8'h0F};
        vt[7] = '{4'h6, 4'h9, 8'hD6};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_tx_valid", tx_valid, 1'b0);
        check("rst_tx_bit", tx_bit, 1'b0);
        check("rst_tx_last", tx_last, 1'b0);
        check("rst_level", fifo_level, 3'd0);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_word_cnt", word_cnt, 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-frame with a word still buffered
        ready_mode = 0;
        push_word(8'hA5, 8'hA5);
        push_word(8'h3C, 8'h3C);
        push_word(8'h0F, 8'h0F);
        repeat (12) @(posedge clk);
        #1;
        check("pre_rst_word_cnt", word_cnt, 32'd1);
        check("pre_rst_valid", tx_valid, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_tx_valid", tx_valid, 1'b0);
        check("midrst_level", fifo_level, 3'd0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_word_cnt", word_cnt, 32'd0);
        q.delete();
        tot = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single word, latency of one cycle after push
        in_valid = 1'b1;
        in_data  = 8'hEA;
        q.push_back(8'hEA);
        tot++;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("lat_valid_n", tx_valid, 1'b0);
        check("lat_level_n", fifo_level, 3'd1);
        @(posedge clk);
        #1;
        check("lat_valid_n1", tx_valid, 1'b1);
        check("lat_bit_n1", tx_bit, 1'b1);
        check("lat_last_n1", tx_last, 1'b0);
        drain("single");

        // Back-to-back words with no bubble
        begin
            int hi = 0;
            push_word(8'h7F, 8'h7F);
            push_word(8'h80, 8'h80);
            repeat (16) begin
                if (tx_valid) hi++;
                @(posedge clk);
                #1;
            end
            check("b2b_contiguous", hi, 16);
            check("b2b_end_valid", tx_valid, 1'b0);
        end
        drain("b2b");

        // FIFO full: one word in the shifter, four buffered, sixth dropped
        ready_mode = 2;
        @(posedge clk);
        #1;
        push_expect(8'h11, 1'b1);
        push_expect(8'h22, 1'b1);
        push_expect(8'h33, 1'b1);
        push_expect(8'h44, 1'b1);
        push_expect(8'h55, 1'b1);
        push_expect(8'h66, 1'b0);
        check("full_level", fifo_level, 3'd4);
        check("full_in_ready", in_ready, 1'b0);
        ready_mode = 0;
        drain("full");

        // Backpressure toggling every cycle
        ready_mode = 1;
        push_word(8'h3C, 8'h3C);
        drain("bp");

        // Table of signed operand pairs
        ready_mode = 0;
        for (int i = 0; i < 8; i++) begin
            push_word(smul(vt[i].a, vt[i].b), vt[i].p);
        end
        drain("table");

        // Random products with random backpressure and idle gaps
        ready_mode = 3;
        for (int i = 0; i < 1000; i++) begin
            logic [3:0] ra;
            logic [3:0] rb;
            logic [7:0] pr;
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            pr = smul(ra, rb);
            push_word(pr, pr);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        ready_mode = 0;
        drain("random");
        check("final_word_cnt", word_cnt, 32'd1017);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
